// File: rtl/wave_pkg.sv
// Shared types and constants for the NCO frequency-sweep sequencer.
package wave_pkg;

  // Sweep behaviour once the stop value is reached; RSVD behaves as SINGLE.
  typedef enum logic [1:0] {
    SINGLE   = 2'b00,
    REPEAT   = 2'b01,
    PINGPONG = 2'b10,
    RSVD     = 2'b11
  } sweep_mode_e;

  // Sequencer state: idle, ascending or descending through phase steps.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } sweep_state_e;

  // Smallest dwell; a programmed dwell of 0 is promoted to this.
  localparam int DWELL_MIN = 1;

endpackage : wave_pkg

// File: rtl/sweep_dwell_timer.sv
// Dwell timer: counts sample ticks per sweep step and flags the terminal tick.
module sweep_dwell_timer
  import wave_pkg::*;
#(
  parameter int SIZE_DWELL = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [SIZE_DWELL-1:0] i_load_val,
  input  logic                  i_run,
  input  logic                  i_tick,
  input  logic [SIZE_DWELL-1:0] i_reload_val,
  output logic                  o_term
);

  localparam logic [SIZE_DWELL-1:0] ONE = SIZE_DWELL'(DWELL_MIN);

  logic [SIZE_DWELL-1:0] r_count;

  // The tick that finds the counter at 1 ends the current step.
  assign o_term = i_run & i_tick & (r_count <= ONE);

  // Load on sweep start, count down on ticks, reload on the terminal tick.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order within or across blocks.
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_run && i_tick) begin
      r_count <= o_term ? i_reload_val : (r_count - ONE);
    end
  end

endmodule : sweep_dwell_timer

// File: rtl/nco_sweep_sequencer.sv
// Frequency-sweep controller driving the NCO phase-step input.
module nco_sweep_sequencer
  import wave_pkg::*;
#(
  parameter int SIZE_PHASE = 10,
  parameter int SIZE_DWELL = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_tick,
  input  logic [1:0]            i_mode,
  input  logic [SIZE_PHASE-1:0] i_phase_start,
  input  logic [SIZE_PHASE-1:0] i_phase_stop,
  input  logic [SIZE_PHASE-1:0] i_phase_inc,
  input  logic [SIZE_DWELL-1:0] i_dwell,
  output logic [SIZE_PHASE-1:0] o_phase_step,
  output logic                  o_busy,
  output logic                  o_dir_down,
  output logic                  o_wrap,
  output logic                  o_done,
  output logic                  o_cfg_err
);

  localparam int W = SIZE_PHASE;

  sweep_state_e          r_state, w_state_nxt;
  logic [W-1:0]          r_phase, w_phase_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_dir_down, w_dir_down_nxt;
  logic                  r_wrap, w_wrap_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_cfg_err, w_cfg_err_nxt;

  logic [W-1:0]          r_cfg_start, r_cfg_stop, r_cfg_inc;
  sweep_mode_e           r_cfg_mode;
  logic [SIZE_DWELL-1:0] r_cfg_dwell;

  logic [SIZE_DWELL-1:0] w_dwell_in;
  logic                  w_cfg_ok;
  logic                  w_accept;
  logic                  w_term;
  logic [W:0]            w_up_sum;
  logic [W-1:0]          w_up_next;
  logic signed [W:0]     w_dn_diff;
  logic [W-1:0]          w_dn_next;

  assign w_dwell_in = (i_dwell == '0) ? SIZE_DWELL'(DWELL_MIN) : i_dwell;
  assign w_cfg_ok   = (i_phase_inc != '0) && (i_phase_start <= i_phase_stop);
  assign w_accept   = (r_state == IDLE) && i_start && !i_abort && w_cfg_ok;

  // Extra bit keeps the sum/difference from wrapping before clamping.
  assign w_up_sum  = {1'b0, r_phase} + {1'b0, r_cfg_inc};
  assign w_up_next = (w_up_sum > {1'b0, r_cfg_stop}) ? r_cfg_stop : w_up_sum[W-1:0];
  assign w_dn_diff = $signed({1'b0, r_phase}) - $signed({1'b0, r_cfg_inc});
  assign w_dn_next = (w_dn_diff < $signed({1'b0, r_cfg_start})) ? r_cfg_start
                                                                 : w_dn_diff[W-1:0];

  sweep_dwell_timer #(.SIZE_DWELL(SIZE_DWELL)) u_dwell (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_accept),
    .i_load_val   (w_dwell_in),
    .i_run        (r_state != IDLE),
    .i_tick       (i_tick),
    .i_reload_val (r_cfg_dwell),
    .o_term       (w_term)
  );

  // Next-state and next-output decode for the sweep FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_busy_nxt     = r_busy;
    w_dir_down_nxt = r_dir_down;
    w_wrap_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_cfg_err_nxt  = 1'b0;

    if (i_abort) begin
      w_state_nxt    = IDLE;
      w_busy_nxt     = 1'b0;
      w_dir_down_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (!w_cfg_ok) begin
              w_cfg_err_nxt = 1'b1;
            end else begin
              w_state_nxt    = UP;
              w_phase_nxt    = i_phase_start;
              w_busy_nxt     = 1'b1;
              w_dir_down_nxt = 1'b0;
            end
          end
        end
        UP: begin
          if (w_term) begin
            if (r_phase < r_cfg_stop) begin
              w_phase_nxt = w_up_next;
            end else begin
              case (r_cfg_mode)
                REPEAT: begin
                  w_phase_nxt = r_cfg_start;
                  w_wrap_nxt  = 1'b1;
                end
                PINGPONG: begin
                  w_state_nxt    = DOWN;
                  w_dir_down_nxt = 1'b1;
                  w_wrap_nxt     = 1'b1;
                  w_phase_nxt    = w_dn_next;
                end
                default: begin
                  w_state_nxt = IDLE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                end
              endcase
            end
          end
        end
        DOWN: begin
          if (w_term) begin
            if (r_phase > r_cfg_start) begin
              w_phase_nxt = w_dn_next;
            end else begin
              w_state_nxt    = UP;
              w_dir_down_nxt = 1'b0;
              w_wrap_nxt     = 1'b1;
              w_phase_nxt    = w_up_next;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_busy     <= 1'b0;
      r_dir_down <= 1'b0;
      r_wrap     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_busy     <= w_busy_nxt;
      r_dir_down <= w_dir_down_nxt;
      r_wrap     <= w_wrap_nxt;
      r_done     <= w_done_nxt;
      r_cfg_err  <= w_cfg_err_nxt;
    end
  end

  // Configuration snapshot taken when a sweep is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cfg_start <= '0;
      r_cfg_stop  <= '0;
      r_cfg_inc   <= '0;
      r_cfg_mode  <= SINGLE;
      r_cfg_dwell <= '0;
    end else if (w_accept) begin
      r_cfg_start <= i_phase_start;
      r_cfg_stop  <= i_phase_stop;
      r_cfg_inc   <= i_phase_inc;
      r_cfg_mode  <= sweep_mode_e'(i_mode);
      r_cfg_dwell <= w_dwell_in;
    end
  end

  assign o_phase_step = r_phase;
  assign o_busy       = r_busy;
  assign o_dir_down   = r_dir_down;
  assign o_wrap       = r_wrap;
  assign o_done       = r_done;
  assign o_cfg_err    = r_cfg_err;

endmodule : nco_sweep_sequencer

// File: tb/tb_nco_sweep_sequencer.sv
// Self-checking bench for nco_sweep_sequencer: behavioural model feeds a
// scoreboard queue each cycle; DUT outputs are popped and compared after the edge.
module tb_nco_sweep_sequencer;

  localparam int SP = 10;
  localparam int SD = 16;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic          i_tick = 1'b0;
  logic [1:0]    i_mode = '0;
  logic [SP-1:0] i_phase_start = '0;
  logic [SP-1:0] i_phase_stop = '0;
  logic [SP-1:0] i_phase_inc = '0;
  logic [SD-1:0] i_dwell = '0;
  logic [SP-1:0] o_phase_step;
  logic          o_busy, o_dir_down, o_wrap, o_done, o_cfg_err;

  nco_sweep_sequencer #(.SIZE_PHASE(SP), .SIZE_DWELL(SD)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_tick        (i_tick),
    .i_mode        (i_mode),
    .i_phase_start (i_phase_start),
    .i_phase_stop  (i_phase_stop),
    .i_phase_inc   (i_phase_inc),
    .i_dwell       (i_dwell),
    .o_phase_step  (o_phase_step),
    .o_busy        (o_busy),
    .o_dir_down    (o_dir_down),
    .o_wrap        (o_wrap),
    .o_done        (o_done),
    .o_cfg_err     (o_cfg_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int phase;
    int flags;  // {busy, dir_down, wrap, done, cfg_err}
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state (0 idle, 1 up, 2 down).
  int m_state = 0, m_phase = 0, m_dir = 0, m_cnt = 0;
  int m_ps = 0, m_pe = 0, m_inc = 0, m_mode = 0, m_dw = 0;
  int m_wrap = 0, m_done = 0, m_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d (0x%0h) expected %0d (0x%0h)", tag, $time, obs, obs, exp, exp);
    end
  endtask

  task automatic model_advance();
    if (m_state == 1) begin
      if (m_phase < m_pe) begin
        m_phase = (m_phase + m_inc > m_pe) ? m_pe : m_phase + m_inc;
      end else if (m_mode == 1) begin
        m_phase = m_ps;
        m_wrap  = 1;
      end else if (m_mode == 2) begin
        m_state = 2;
        m_dir   = 1;
        m_wrap  = 1;
        m_phase = (m_pe - m_inc < m_ps) ? m_ps : m_pe - m_inc;
      end else begin
        m_state = 0;
        m_done  = 1;
      end
    end else begin
      if (m_phase > m_ps) begin
        m_phase = (m_phase - m_inc < m_ps) ? m_ps : m_phase - m_inc;
      end else begin
        m_state = 1;
        m_dir   = 0;
        m_wrap  = 1;
        m_phase = (m_ps + m_inc > m_pe) ? m_pe : m_ps + m_inc;
      end
    end
  endtask

  task automatic model_step();
    m_wrap = 0; m_done = 0; m_err = 0;
    if (i_rst) begin
      m_state = 0; m_phase = 0; m_dir = 0; m_cnt = 0;
      m_ps = 0; m_pe = 0; m_inc = 0; m_mode = 0; m_dw = 0;
    end else if (i_abort) begin
      m_state = 0;
      m_dir   = 0;
    end else if (m_state == 0) begin
      if (i_start) begin
        if (i_phase_inc == 0 || i_phase_start > i_phase_stop) begin
          m_err = 1;
        end else begin
          m_ps = int'(i_phase_start); m_pe = int'(i_phase_stop);
          m_inc = int'(i_phase_inc); m_mode = int'(i_mode);
          m_dw = (i_dwell == 0) ? 1 : int'(i_dwell);
          m_cnt = m_dw; m_state = 1; m_phase = m_ps; m_dir = 0;
        end
      end
    end else if (i_tick) begin
      if (m_cnt > 1) m_cnt--;
      else begin
        m_cnt = m_dw;
        model_advance();
      end
    end
  endtask

  // One clock: predict, push, clock, pop, compare.
  task automatic cyc();
    exp_t e;
    model_step();
    e.phase = m_phase;
    e.flags = ((m_state != 0) ? 16 : 0) + m_dir * 8 + m_wrap * 4 + m_done * 2 + m_err;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    e = sb.pop_front();
    check("phase_step", int'(o_phase_step), e.phase);
    check("flags{busy,dir,wrap,done,err}",
          int'({o_busy, o_dir_down, o_wrap, o_done, o_cfg_err}), e.flags);
  endtask

  task automatic run(input int n);
    i_tick = 1'b1;
    repeat (n) cyc();
  endtask

  task automatic set_cfg(input int mode, input int ps, input int pe, input int inc, input int dw);
    i_mode = 2'(mode);
    i_phase_start = SP'(ps);
    i_phase_stop = SP'(pe);
    i_phase_inc = SP'(inc);
    i_dwell = SD'(dw);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic pulse_abort();
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) cyc();
    check("reset_busy", int'(o_busy), 0);
    i_rst = 1'b0;

    // SINGLE 10..30 step 8 dwell 2, then idle with ticks off
    set_cfg(0, 10, 30, 8, 2);
    pulse_start();
    run(12);
    check("single_end_phase", int'(o_phase_step), 30);
    check("single_end_busy", int'(o_busy), 0);
    i_tick = 1'b0;
    repeat (3) cyc();

    // REPEAT 4..12 step 4 dwell 1, then reset mid-sweep
    set_cfg(1, 4, 12, 4, 1);
    pulse_start();
    run(9);
    i_rst = 1'b1; i_start = 1'b1; i_tick = 1'b1;
    cyc();
    i_rst = 1'b0; i_start = 1'b0;
    check("rst_mid_phase", int'(o_phase_step), 0);

    // PINGPONG 0..10 step 4 dwell 1
    set_cfg(2, 0, 10, 4, 1);
    pulse_start();
    run(12);
    pulse_abort();

    // Config errors
    set_cfg(0, 0, 10, 0, 1);
    pulse_start();
    cyc();
    set_cfg(0, 20, 5, 1, 1);
    pulse_start();
    cyc();

    // Abort and start together in IDLE: no start
    set_cfg(0, 10, 30, 8, 2);
    i_start = 1'b1; i_abort = 1'b1;
    cyc();
    i_start = 1'b0; i_abort = 1'b0;
    check("abort_start_busy", int'(o_busy), 0);

    // Abort at step 18
    pulse_start();
    i_tick = 1'b1;
    for (int k = 0; k < 20 && m_phase != 18; k++) cyc();
    check("reached_18", m_phase, 18);
    pulse_abort();
    check("abort_hold_phase", int'(o_phase_step), 18);
    run(3);

    // Start during UP is ignored
    pulse_start();
    run(2);
    set_cfg(1, 0, 5, 1, 1);
    pulse_start();
    run(12);
    check("ignored_start_end", int'(o_phase_step), 30);

    // Sparse random ticks, PINGPONG dwell 3, stray starts mid-sweep
    set_cfg(2, 100, 140, 7, 3);
    pulse_start();
    for (int k = 0; k < 120; k++) begin
      i_tick  = 1'($urandom_range(0, 1));
      i_start = ($urandom_range(0, 15) == 0);
      cyc();
    end
    i_start = 1'b0;
    pulse_abort();

    // start==stop: REPEAT with dwell 0, SINGLE, reserved mode
    set_cfg(1, 5, 5, 3, 0);
    pulse_start();
    run(5);
    pulse_abort();
    set_cfg(2, 9, 9, 2, 1);
    pulse_start();
    run(5);
    pulse_abort();
    set_cfg(0, 7, 7, 1, 0);
    pulse_start();
    run(3);
    set_cfg(3, 0, 9, 5, 1);
    pulse_start();
    run(5);
    set_cfg(2, 1000, 1023, 20, 1);
    pulse_start();
    run(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_nco_sweep_sequencer
